biriscv_wb_merge: RTL and testbench

BIRISCV_WB_MERGE -- requirements
Module: biriscv_wb_merge

---
 rtl/biriscv_wb_pkg.sv | 14 +
 rtl/biriscv_wb_fifo.sv | 66 ++++++
 rtl/biriscv_wb_merge.sv | 102 ++++++++++
 tb/tb_biriscv_wb_merge.sv | 135 +++++++++++++
 4 files changed

// File: rtl/biriscv_wb_pkg.sv
// Shared types and defaults for the writeback merge queue.
package biriscv_wb_pkg;

  localparam int unsigned WB_DEPTH_DEFAULT = 4;
  localparam int unsigned RD_W             = 5;
  localparam int unsigned VALUE_W          = 32;

  // One queued register-file write.
  typedef struct packed {
    logic [RD_W-1:0]    rd;
    logic [VALUE_W-1:0] value;
  } wb_entry_t;

endpackage

// File: rtl/biriscv_wb_fifo.sv
// Circular queue with two ordered push slots (a before b) and one pop per cycle.
module biriscv_wb_fifo
  import biriscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_a_i,
  input  wb_entry_t             push_a_data_i,
  input  logic                  push_b_i,
  input  wb_entry_t             push_b_data_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CNT_W-1:0]      count_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]      valid_o
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_i);
    count_d    = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
  end

  // Pointer and count registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; slot b lands directly behind slot a.
  always_ff @(posedge clk_i) begin
    if (push_a_i) mem_q[wr_ptr_q]   <= push_a_data_i;
    if (push_b_i) mem_q[wr_ptr_nxt] <= push_b_data_i;
  end

  // Occupied-slot mask for hazard comparison: slot is live if its distance from head < count.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      valid_o[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/biriscv_wb_merge.sv
// Merges two in-order writeback streams onto the single register-file write port.
module biriscv_wb_merge
  import biriscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb0_valid_i,
  input  logic [RD_W-1:0]    wb0_rd_i,
  input  logic [VALUE_W-1:0] wb0_value_i,
  output logic               wb0_ready_o,
  input  logic               wb1_valid_i,
  input  logic [RD_W-1:0]    wb1_rd_i,
  input  logic [VALUE_W-1:0] wb1_value_i,
  output logic               wb1_ready_o,
  output logic [RD_W-1:0]    rd0_o,
  output logic [VALUE_W-1:0] rd0_value_o,
  input  logic [RD_W-1:0]    ra_i,
  input  logic [RD_W-1:0]    rb_i,
  output logic               ra_pending_o,
  output logic               rb_pending_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t             head, first, second, push_a_data, push_b_data;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [CNT_W-1:0]      count;
  logic                  en0, en1, first_v, second_v, pop, push_a, push_b;
  wb_entry_t             out_q, out_d;

  // Readies from pre-pop occupancy; wb1 must leave room for wb0 when both request.
  always_comb begin
    wb0_ready_o = rst_i && (count <= CNT_W'(DEPTH - 1));
    wb1_ready_o = rst_i && (wb0_valid_i ? (count <= CNT_W'(DEPTH - 2))
                                        : (count <= CNT_W'(DEPTH - 1)));
  end

  // Compact accepted nonzero-rd writes in program order; bypass the queue when empty.
  always_comb begin
    en0      = wb0_valid_i && wb0_ready_o && (wb0_rd_i != '0);
    en1      = wb1_valid_i && wb1_ready_o && (wb1_rd_i != '0);
    first    = en0 ? '{rd: wb0_rd_i, value: wb0_value_i} : '{rd: wb1_rd_i, value: wb1_value_i};
    second   = '{rd: wb1_rd_i, value: wb1_value_i};
    first_v  = en0 || en1;
    second_v = en0 && en1;
    pop      = (count != '0);
    if (pop) begin
      out_d       = head;
      push_a      = first_v;
      push_a_data = first;
      push_b      = second_v;
      push_b_data = second;
    end else begin
      out_d       = first_v ? first : '0;
      push_a      = second_v;
      push_a_data = second;
      push_b      = 1'b0;
      push_b_data = second;
    end
  end

  // Single-entry output register feeding the write port.
  always_ff @(posedge clk_i) begin
    if (!rst_i) out_q <= '0;
    else        out_q <= out_d;
  end

  biriscv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_a_i      (push_a),
    .push_a_data_i (push_a_data),
    .push_b_i      (push_b),
    .push_b_data_i (push_b_data),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (count),
    .entries_o     (entries),
    .valid_o       (valid)
  );

  // Hazard compare against every live queue slot and the write in flight.
  always_comb begin
    ra_pending_o = 1'b0;
    rb_pending_o = 1'b0;
    if (rst_i) begin
      if (ra_i != '0 && out_q.rd == ra_i) ra_pending_o = 1'b1;
      if (rb_i != '0 && out_q.rd == rb_i) rb_pending_o = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ra_i != '0 && valid[i] && entries[i].rd == ra_i) ra_pending_o = 1'b1;
        if (rb_i != '0 && valid[i] && entries[i].rd == rb_i) rb_pending_o = 1'b1;
      end
    end
  end

  assign rd0_o       = out_q.rd;
  assign rd0_value_o = out_q.value;

endmodule

// File: tb/tb_biriscv_wb_merge.sv
// Bench for biriscv_wb_merge: directed cases plus random traffic against a queue model.
module tb_biriscv_wb_merge;
  import biriscv_wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        wb0_valid_i = 1'b0, wb1_valid_i = 1'b0;
  logic [4:0]  wb0_rd_i = '0, wb1_rd_i = '0, ra_i = '0, rb_i = '0;
  logic [31:0] wb0_value_i = '0, wb1_value_i = '0;
  logic        wb0_ready_o, wb1_ready_o, ra_pending_o, rb_pending_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;

  int n_vec = 0;
  int n_err = 0;

  // Model: writes accepted but not yet presented, in program order, and the write presented now.
  wb_entry_t pend_q[$];
  wb_entry_t exp_out = '0;

  always #5 clk_i = ~clk_i;

  biriscv_wb_merge #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb0_valid_i  (wb0_valid_i),
    .wb0_rd_i     (wb0_rd_i),
    .wb0_value_i  (wb0_value_i),
    .wb0_ready_o  (wb0_ready_o),
    .wb1_valid_i  (wb1_valid_i),
    .wb1_rd_i     (wb1_rd_i),
    .wb1_value_i  (wb1_value_i),
    .wb1_ready_o  (wb1_ready_o),
    .rd0_o        (rd0_o),
    .rd0_value_o  (rd0_value_o),
    .ra_i         (ra_i),
    .rb_i         (rb_i),
    .ra_pending_o (ra_pending_o),
    .rb_pending_o (rb_pending_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (exp_out.rd == r) return 1'b1;
    foreach (pend_q[i]) if (pend_q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check the registered write port, drive inputs, check combinational outputs, advance model.
  task automatic step(input logic rst, input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic e_r0, e_r1;
    int   cnt;
    @(negedge clk_i);
    check("rd0", 32'(rd0_o), 32'(exp_out.rd));
    check("rd0_value", rd0_value_o, exp_out.value);
    rst_i = rst; wb0_valid_i = v0; wb0_rd_i = r0; wb0_value_i = d0;
    wb1_valid_i = v1; wb1_rd_i = r1; wb1_value_i = d1; ra_i = ra; rb_i = rb;
    #1;
    cnt  = pend_q.size();
    e_r0 = rst && (cnt <= int'(DEPTH) - 1);
    e_r1 = rst && (v0 ? (cnt <= int'(DEPTH) - 2) : (cnt <= int'(DEPTH) - 1));
    check("wb0_ready", 32'(wb0_ready_o), 32'(e_r0));
    check("wb1_ready", 32'(wb1_ready_o), 32'(e_r1));
    check("ra_pending", 32'(ra_pending_o), 32'(rst && model_pending(ra)));
    check("rb_pending", 32'(rb_pending_o), 32'(rst && model_pending(rb)));
    if (!rst) begin
      pend_q.delete();
      exp_out = '0;
    end else begin
      if (v0 && e_r0 && r0 != 5'd0) pend_q.push_back('{rd: r0, value: d0});
      if (v1 && e_r1 && r1 != 5'd0) pend_q.push_back('{rd: r1, value: d1});
      exp_out = (pend_q.size() > 0) ? pend_q.pop_front() : '0;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] ra, input logic [4:0] rb);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Single request through the empty queue.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(3, 5'd5, 5'd0);

    // Same-cycle writes to one register: wb0 then wb1.
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0, 5'd3);
    idle(3, 5'd0, 5'd3);

    // Both ports saturated: readies throttle, order preserved.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 5'(2*i + 1), 32'(32'h100 + i), 1'b1, 5'(2*i + 2), 32'(32'h200 + i),
           5'(2*i + 1), 5'd2);
    idle(6, 5'd7, 5'd8);

    // rd=0 is accepted and discarded.
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Reset with entries queued cancels them.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b1, 5'(20 + i), 32'(32'hB0 + i), 5'd21, 5'd12);
    step(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd9, 32'h99, 5'd21, 5'd12);
    idle(5, 5'd21, 5'd12);

    // Random bursty traffic with small rd range to provoke hazards and collisions.
    for (int i = 0; i < 800; i++) begin
      logic rst, v0, v1;
      rst = ($urandom_range(0, 60) != 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      step(rst, v0, 5'($urandom_range(0, 7)), $urandom(), v1, 5'($urandom_range(0, 7)), $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6, 5'd1, 5'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
